// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: turns the prescaler's slow square wave, or a debounced
// step push-button, into a one-cycle cpu_tick enable in the clock_in domain.
// The controller runs free (AUTO), single-steps (MANUAL) or stops on the
// core's request (HALT).
//
// state  | meaning
// -------+---------------------------------------------------------------
// MANUAL | one tick per debounced rising edge of step_button
// AUTO   | one tick per synchronized rising edge of slow_clock
// HALT   | no ticks; a step press with halt_req low leaves, without a tick

// Debouncer: the synchronized input must differ from the accepted level for
// DEBOUNCE_CYCLES consecutive edges before the new level is taken.
module cpu_clock_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic din,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // Count while the input disagrees; clear on agreement or on acceptance.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (din != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = din;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter and accepted level registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

module cpu_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic slow_clock,
  input  logic step_button,
  input  logic mode_switch,
  input  logic halt_req,
  output logic cpu_tick,
  output logic mode_auto,
  output logic halted
);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] slow_sync_q, slow_sync_d;
  logic [SYNC_STAGES-1:0] step_sync_q, step_sync_d;
  logic [SYNC_STAGES-1:0] mode_sync_q, mode_sync_d;

  logic slow_prev_q, slow_prev_d;
  logic step_prev_q, step_prev_d;

  logic step_level;
  logic mode_level;
  logic auto_evt;
  logic step_evt;

  state_t state_q, state_d;
  logic   tick_q, tick_d;
  logic   mode_auto_q, mode_auto_d;
  logic   halted_q, halted_d;

  // Shift the three asynchronous inputs into their synchronizer chains.
  always_comb begin
    slow_sync_d = {slow_sync_q[SYNC_STAGES-2:0], slow_clock};
    step_sync_d = {step_sync_q[SYNC_STAGES-2:0], step_button};
    mode_sync_d = {mode_sync_q[SYNC_STAGES-2:0], mode_switch};
  end

  // Synchronizer registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      slow_sync_q <= '0;
      step_sync_q <= '0;
      mode_sync_q <= '0;
    end else begin
      slow_sync_q <= slow_sync_d;
      step_sync_q <= step_sync_d;
      mode_sync_q <= mode_sync_d;
    end
  end

  cpu_clock_ctrl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clock_in(clock_in),
    .reset_n (reset_n),
    .din     (step_sync_q[SYNC_STAGES-1]),
    .level   (step_level)
  );

  cpu_clock_ctrl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_db (
    .clock_in(clock_in),
    .reset_n (reset_n),
    .din     (mode_sync_q[SYNC_STAGES-1]),
    .level   (mode_level)
  );

  // Rising-edge detection on the synced slow clock and debounced button.
  always_comb begin
    slow_prev_d = slow_sync_q[SYNC_STAGES-1];
    step_prev_d = step_level;
    auto_evt    = slow_sync_q[SYNC_STAGES-1] & ~slow_prev_q;
    step_evt    = step_level & ~step_prev_q;
  end

  // Edge-detect history registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      slow_prev_q <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      slow_prev_q <= slow_prev_d;
      step_prev_q <= step_prev_d;
    end
  end

  // Next state, tick and LED decodes. The tick looks at the current state,
  // so an event coinciding with a mode change is judged by the old mode.
  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    if (halt_req) begin
      state_d = ST_HALT;
    end else begin
      unique case (state_q)
        ST_MANUAL: begin
          tick_d = step_evt;
          if (mode_level) state_d = ST_AUTO;
        end
        ST_AUTO: begin
          tick_d = auto_evt;
          if (!mode_level) state_d = ST_MANUAL;
        end
        ST_HALT: begin
          if (step_evt) state_d = mode_level ? ST_AUTO : ST_MANUAL;
        end
        default: state_d = ST_MANUAL;
      endcase
    end
    mode_auto_d = (state_d == ST_AUTO);
    halted_d    = (state_d == ST_HALT);
  end

  // State, tick and LED registers; the LEDs track the state register exactly.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_MANUAL;
      tick_q      <= 1'b0;
      mode_auto_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      mode_auto_q <= mode_auto_d;
      halted_q    <= halted_d;
    end
  end

  assign cpu_tick  = tick_q;
  assign mode_auto = mode_auto_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2.
module tb_cpu_clock_ctrl;

  logic clock_in;
  logic reset_n;
  logic slow_clock;
  logic step_button;
  logic mode_switch;
  logic halt_req;
  logic cpu_tick;
  logic mode_auto;
  logic halted;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;
  int dbl_cnt  = 0;
  logic tick_prev = 1'b0;

  cpu_clock_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .slow_clock (slow_clock),
    .step_button(step_button),
    .mode_switch(mode_switch),
    .halt_req   (halt_req),
    .cpu_tick   (cpu_tick),
    .mode_auto  (mode_auto),
    .halted     (halted)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Count tick pulses and any pulse wider than one cycle.
  always @(negedge clock_in) begin
    if (cpu_tick) tick_cnt++;
    if (cpu_tick && tick_prev) dbl_cnt++;
    tick_prev = cpu_tick;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n falling edges, then settle 1 ns past them.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock_in);
    #1;
  endtask

  // One slow_clock period (10 high, 10 low) with tick-latency checks.
  task automatic slow_period(input string tag, input int exp_tick);
    slow_clock = 1'b1;
    wait_cyc(2);
    chk({tag, "_pre"}, int'(cpu_tick), 0);
    wait_cyc(1);
    chk({tag, "_edge3"}, int'(cpu_tick), exp_tick);
    wait_cyc(1);
    chk({tag, "_post"}, int'(cpu_tick), 0);
    wait_cyc(6);
    slow_clock = 1'b0;
    wait_cyc(10);
  endtask

  initial begin
    int base;
    int lat;
    bit seen;

    reset_n     = 1'b0;
    slow_clock  = 1'b0;
    step_button = 1'b0;
    mode_switch = 1'b0;
    halt_req    = 1'b0;
    wait_cyc(3);
    chk("rst_tick", int'(cpu_tick), 0);
    chk("rst_auto", int'(mode_auto), 0);
    chk("rst_halt", int'(halted), 0);
    reset_n = 1'b1;
    wait_cyc(2);

    // MANUAL: slow clock alone must never tick.
    for (int p = 0; p < 10; p++) slow_period("man_slow", 0);
    chk("man_slow_cnt", tick_cnt, 0);
    chk("man_auto", int'(mode_auto), 0);
    chk("man_halt", int'(halted), 0);

    // Three 3-cycle bounces are too short to be accepted.
    for (int b = 0; b < 3; b++) begin
      step_button = 1'b1;
      wait_cyc(3);
      step_button = 1'b0;
      wait_cyc(3);
    end
    wait_cyc(6);
    chk("bounce_cnt", tick_cnt, 0);

    // Held press: tick at the 7th edge after the level goes high, once only.
    step_button = 1'b1;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20; i++) begin
      wait_cyc(1);
      if (!seen && cpu_tick) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk("step_seen", int'(seen), 1);
    chk("step_latency", lat, 7);
    step_button = 1'b0;
    wait_cyc(10);
    chk("step_cnt", tick_cnt, 1);

    // Switch to AUTO; 10 slow periods give 10 ticks, button ignored.
    mode_switch = 1'b1;
    wait_cyc(10);
    chk("auto_led", int'(mode_auto), 1);
    chk("auto_halt", int'(halted), 0);
    base = tick_cnt;
    for (int p = 0; p < 10; p++) begin
      if (p == 2) step_button = 1'b1;
      if (p == 6) step_button = 1'b0;
      slow_period("auto_slow", 1);
    end
    chk("auto_cnt", tick_cnt - base, 10);

    // halt_req on the same edge as auto_evt suppresses the tick.
    base = tick_cnt;
    slow_clock = 1'b1;
    wait_cyc(2);
    halt_req = 1'b1;
    wait_cyc(1);
    chk("halt_tick", int'(cpu_tick), 0);
    chk("halt_led", int'(halted), 1);
    chk("halt_auto", int'(mode_auto), 0);
    wait_cyc(7);
    slow_clock = 1'b0;
    wait_cyc(10);
    for (int p = 0; p < 2; p++) slow_period("halt_slow", 0);
    halt_req = 1'b0;
    wait_cyc(3);
    chk("halt_hold", int'(halted), 1);
    chk("halt_cnt", tick_cnt - base, 0);

    // Step press leaves HALT into AUTO without a tick.
    step_button = 1'b1;
    wait_cyc(12);
    chk("exit_auto", int'(mode_auto), 1);
    chk("exit_halt", int'(halted), 0);
    chk("exit_cnt", tick_cnt - base, 0);
    step_button = 1'b0;
    wait_cyc(10);
    slow_period("resume", 1);
    chk("resume_cnt", tick_cnt - base, 1);

    // Asynchronous reset while a tick is high.
    slow_clock = 1'b1;
    wait_cyc(3);
    chk("pre_rst_tick", int'(cpu_tick), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_tick", int'(cpu_tick), 0);
    chk("arst_auto", int'(mode_auto), 0);
    chk("arst_halt", int'(halted), 0);
    slow_clock = 1'b0;
    #10 reset_n = 1'b1;
    base = tick_cnt;
    wait_cyc(1);
    chk("post_rst_auto0", int'(mode_auto), 0);
    wait_cyc(3);
    chk("post_rst_auto1", int'(mode_auto), 0);
    wait_cyc(6);
    chk("post_rst_auto2", int'(mode_auto), 1);
    chk("post_rst_cnt", tick_cnt - base, 0);
    chk("pulse_width", dbl_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
- Sits directly downstream of the prescaler. Consumes its slow square-wave clock and the board's step push-button and mode switch.
- Produces `cpu_tick`, a single-cycle clock-enable pulse in the 100 MHz `clock_in` domain, which advances the TD4 core by one instruction.
- Selects between free-running auto mode and manual single-step mode.
- Enters a halted state on request from the core.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new level on `step_button` or `mode_switch` (10 ms at 100 MHz); must be ≥ 2.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; must be ≥ 2.

Ports:
- clock_in  input  1  system clock, 100 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- slow_clock  input  1  prescaler output; square wave, treated as asynchronous.
- step_button  input  1  raw push-button, active-high, bouncy.
- mode_switch  input  1  raw slide switch; 1 = auto, 0 = manual; bouncy.
- halt_req  input  1  synchronous to `clock_in`, from the core; level, 1 = stop ticking.
- cpu_tick  output  1  one-cycle enable pulse to the core.
- mode_auto  output  1  1 when the FSM is in AUTO (LED).
- halted  output  1  1 when the FSM is in HALT (LED).

Behaviour:
- Reset (`reset_n` = 0, asynchronous, any time):
  - all synchronizer flops, debounced levels, the edge-detect register and debounce counters clear to 0;
  - FSM goes to MANUAL;
  - `cpu_tick`, `mode_auto` and `halted` are 0.
  - Reset is released synchronously via normal flop behaviour; a tick pending mid-reset is discarded.
- Synchronizers: `slow_clock`, `step_button` and `mode_switch` each pass through SYNC_STAGES flops. `halt_req` is not synchronized.
- Debounce (separate instance each for `step_button` and `mode_switch`):
  - the counter increments while the synced input differs from the debounced level;
  - it clears to 0 whenever they match;
  - when the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the synced value on that edge and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change the debounced level.
  - Counter width is clog2(DEBOUNCE_CYCLES); no wrap is possible.
- Events (all combinational from registered state):
  - auto_evt = rising edge of synced `slow_clock` (synced value 1, previous value 0);
  - step_evt = rising edge of debounced `step_button`.
- FSM states MANUAL, AUTO, HALT. Priority order:
  - any state with `halt_req` = 1 goes to HALT;
  - MANUAL goes to AUTO when debounced mode = 1;
  - AUTO goes to MANUAL when debounced mode = 0;
  - HALT goes to AUTO (debounced mode = 1) or MANUAL (mode = 0) only when step_evt occurs and `halt_req` = 0;
  - otherwise the FSM holds its state.
- Tick generation (`cpu_tick` is registered):
  - `cpu_tick` next = (state = AUTO and auto_evt) or (state = MANUAL and step_evt), both qualified by `halt_req` = 0;
  - the pulse is exactly one cycle wide;
  - the step_evt that exits HALT does not itself produce a tick.
  - In AUTO, step_evt is ignored. In MANUAL, auto_evt is ignored.
- Simultaneous events:
  - a mode change and an event on the same edge: the tick is decided by the current (pre-transition) state;
  - `halt_req` on the same edge as an event suppresses the tick.
- Latency (SYNC_STAGES = 2), counting the edge that first samples `slow_clock` high as edge 1:
  - `cpu_tick` is high in the cycle following edge 3;
  - the first tick after a mode change comes only from events evaluated after the state update.
- Outputs:
  - `mode_auto` = (state = AUTO);
  - `halted` = (state = HALT);
  - both are registered state decodes, so there are no glitches.
- Throughput: at most one tick per `slow_clock` period in AUTO and one per debounced press in MANUAL. Holding the button produces exactly one tick.

Test Plan:
- Reset, then MANUAL with `mode_switch` = 0. Drive `slow_clock` with a 20-cycle period for 200 cycles → `cpu_tick` never asserts; `mode_auto` = 0, `halted` = 0.
- DEBOUNCE_CYCLES = 4, manual mode. Press `step_button` with 3-cycle bounce pulses, then hold for 20 cycles → exactly one 1-cycle `cpu_tick`, within 4+SYNC_STAGES+2 cycles of the stable level. The bounces alone produce none.
- Set `mode_switch` = 1 and hold ≥ 6 cycles; `slow_clock` period 20 for 10 periods → `mode_auto` = 1; exactly 10 `cpu_tick` pulses, each 3 edges after the `slow_clock` rise. Button presses during this add no ticks.
- In AUTO, assert `halt_req` on the same edge as an auto_evt → no tick that cycle; `halted` = 1 next cycle; no further ticks.
- Drop `halt_req`, then press the button → FSM to AUTO (`mode_auto` = 1, `halted` = 0) with no tick for that press; ticks resume on the next `slow_clock` rise.
- Pulse `reset_n` low for 1 cycle mid-AUTO, asynchronously between edges → all outputs 0 immediately; FSM in MANUAL. With `mode_switch` still 1, AUTO is re-entered after debounce (≥ 6 cycles).
